// File: rtl/letter_tracker.sv
// Falling-letter typing game core: holds the on-screen letters, advances them
// once per video frame and resolves keystrokes against the lowest (largest x)
// matching letter.
module letter_tracker #(
  parameter int SLOTS   = 8,
  parameter int X_LIMIT = 480
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     spawn_valid,
  input  logic [7:0]               spawn_ch,
  input  logic [3:0]               spawn_speed,
  input  logic [8:0]               spawn_x,
  input  logic [9:0]               spawn_y,
  output logic                     spawn_ready,
  input  logic                     frame_tick,
  input  logic                     key_valid,
  input  logic [7:0]               key_ch,
  output logic                     key_ready,
  input  logic [$clog2(SLOTS)-1:0] rd_idx,
  output logic                     rd_active,
  output logic [7:0]               rd_ch,
  output logic [8:0]               rd_x,
  output logic [9:0]               rd_y,
  output logic                     hit_pulse,
  output logic                     wrong_pulse,
  output logic                     miss_pulse,
  output logic [15:0]              score,
  output logic [7:0]               miss_count
);

  localparam int IDXW = $clog2(SLOTS);
  localparam int CW   = IDXW + 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(SLOTS - 1);
  localparam logic [9:0]      XLIM     = 10'(X_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    MOVE,
    SCAN,
    RESOLVE
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic            r_active [SLOTS];
  logic [7:0]      r_ch     [SLOTS];
  logic [3:0]      r_speed  [SLOTS];
  logic [8:0]      r_x      [SLOTS];
  logic [9:0]      r_y      [SLOTS];

  logic            r_tickPending;
  logic [7:0]      r_key;
  logic [IDXW-1:0] r_scanIdx;
  logic            r_found;
  logic [IDXW-1:0] r_bestIdx;
  logic [8:0]      r_bestX;
  logic [15:0]     r_score;
  logic [7:0]      r_missCount;
  logic            r_hitPulse;
  logic            r_wrongPulse;
  logic            r_missPulse;

  logic            w_anyFree;
  logic [IDXW-1:0] w_freeIdx;
  logic [9:0]      w_sum [SLOTS];
  logic [SLOTS-1:0] w_fall;
  logic [CW-1:0]   w_fallCount;
  logic [8:0]      w_missSum;
  logic            w_candidate;

  // Lowest-index inactive slot receives the next spawned letter.
  always_comb begin
    w_anyFree = 1'b0;
    w_freeIdx = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!r_active[i]) begin
        w_anyFree = 1'b1;
        w_freeIdx = IDXW'(i);
      end
    end
  end

  // Per-slot advanced position and fall-off detection, evaluated in 10 bits so
  // a letter near the bottom cannot wrap back to the top.
  always_comb begin
    w_fall      = '0;
    w_fallCount = '0;
    for (int i = 0; i < SLOTS; i++) begin
      w_sum[i]  = {1'b0, r_x[i]} + {6'b0, r_speed[i]};
      w_fall[i] = r_active[i] && (w_sum[i] >= XLIM);
      w_fallCount = w_fallCount + {{(CW-1){1'b0}}, w_fall[i]};
    end
  end

  assign w_missSum   = {1'b0, r_missCount} + {{(9-CW){1'b0}}, w_fallCount};
  assign w_candidate = r_active[r_scanIdx] && (r_ch[r_scanIdx] == r_key);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and handshake outputs; a pending frame tick wins over a key.
  always_comb begin
    w_nextState = r_state;
    spawn_ready = 1'b0;
    key_ready   = 1'b0;
    case (r_state)
      IDLE: begin
        spawn_ready = w_anyFree;
        key_ready   = !r_tickPending && !frame_tick;
        if (frame_tick || r_tickPending) begin
          w_nextState = MOVE;
        end else if (key_valid) begin
          w_nextState = SCAN;
        end
      end
      MOVE:    w_nextState = IDLE;
      SCAN: begin
        if (r_scanIdx == LAST_IDX) begin
          w_nextState = RESOLVE;
        end
      end
      RESOLVE: w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Slot storage, frame movement, keystroke search and score/miss bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SLOTS; i++) begin
        r_active[i] <= 1'b0;
        r_ch[i]     <= '0;
        r_speed[i]  <= '0;
        r_x[i]      <= '0;
        r_y[i]      <= '0;
      end
      r_tickPending <= 1'b0;
      r_key         <= '0;
      r_scanIdx     <= '0;
      r_found       <= 1'b0;
      r_bestIdx     <= '0;
      r_bestX       <= '0;
      r_score       <= '0;
      r_missCount   <= '0;
      r_hitPulse    <= 1'b0;
      r_wrongPulse  <= 1'b0;
      r_missPulse   <= 1'b0;
    end else begin
      r_hitPulse   <= 1'b0;
      r_wrongPulse <= 1'b0;
      r_missPulse  <= 1'b0;

      if (r_state == IDLE && w_nextState == MOVE) begin
        r_tickPending <= 1'b0;
      end else if (frame_tick) begin
        r_tickPending <= 1'b1;
      end

      if (spawn_valid && spawn_ready) begin
        r_active[w_freeIdx] <= 1'b1;
        r_ch[w_freeIdx]     <= spawn_ch;
        r_speed[w_freeIdx]  <= spawn_speed;
        r_x[w_freeIdx]      <= spawn_x;
        r_y[w_freeIdx]      <= spawn_y;
      end

      case (r_state)
        IDLE: begin
          if (w_nextState == SCAN) begin
            r_key     <= key_ch;
            r_scanIdx <= '0;
            r_found   <= 1'b0;
            r_bestIdx <= '0;
            r_bestX   <= '0;
          end
        end
        MOVE: begin
          for (int i = 0; i < SLOTS; i++) begin
            if (r_active[i]) begin
              if (w_fall[i]) begin
                r_active[i] <= 1'b0;
              end else begin
                r_x[i] <= w_sum[i][8:0];
              end
            end
          end
          r_missCount <= w_missSum[8] ? 8'hFF : w_missSum[7:0];
          r_missPulse <= |w_fall;
        end
        SCAN: begin
          if (w_candidate && (!r_found || r_x[r_scanIdx] > r_bestX)) begin
            r_found   <= 1'b1;
            r_bestIdx <= r_scanIdx;
            r_bestX   <= r_x[r_scanIdx];
          end
          r_scanIdx <= r_scanIdx + IDXW'(1);
        end
        RESOLVE: begin
          if (r_found) begin
            r_active[r_bestIdx] <= 1'b0;
            if (r_score != 16'hFFFF) begin
              r_score <= r_score + 16'd1;
            end
            r_hitPulse <= 1'b1;
          end else begin
            r_wrongPulse <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_active   = r_active[rd_idx];
  assign rd_ch       = r_ch[rd_idx];
  assign rd_x        = r_x[rd_idx];
  assign rd_y        = r_y[rd_idx];
  assign hit_pulse   = r_hitPulse;
  assign wrong_pulse = r_wrongPulse;
  assign miss_pulse  = r_missPulse;
  assign score       = r_score;
  assign miss_count  = r_missCount;

endmodule

// File: doc/letter_tracker.md
LETTER_TRACKER -- requirements
Module: letter_tracker

Interface
REQ-001 Parameter SLOTS, default 8, number of on-screen letter slots (power of 2, index width 3).
REQ-002 Parameter X_LIMIT, default 480, vertical coordinate at or beyond which a letter has fallen off screen.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 spawn_valid  input  1  new letter offered by the letter generator.
REQ-006 spawn_ch  input  8  ASCII code of offered letter.
REQ-007 spawn_speed  input  4  pixels per frame of offered letter.
REQ-008 spawn_x  input  9  initial vertical position.
REQ-009 spawn_y  input  10  horizontal position.
REQ-010 spawn_ready  output  1  offered letter is accepted this cycle when high with spawn_valid.
REQ-011 frame_tick  input  1  one-cycle pulse per video frame.
REQ-012 key_valid  input  1  keystroke offered.
REQ-013 key_ch  input  8  ASCII code of keystroke.
REQ-014 key_ready  output  1  keystroke accepted this cycle when high with key_valid.
REQ-015 rd_idx  input  3  slot select for display readout.
REQ-016 rd_active, rd_ch[7:0], rd_x[8:0], rd_y[9:0]  output  combinational contents of slot rd_idx.
REQ-017 hit_pulse  output  1  one-cycle pulse, keystroke removed a letter.
REQ-018 wrong_pulse  output  1  one-cycle pulse, keystroke matched no letter.
REQ-019 miss_pulse  output  1  one-cycle pulse, at least one letter fell off.
REQ-020 score  output  16  hit count; miss_count  output  8  missed-letter count.

Function
REQ-021 Each slot SHALL hold active, ch, speed, x, y registers.
REQ-022 States SHALL be IDLE, MOVE, SCAN, RESOLVE.
REQ-023 frame_tick in any state SHALL set tick_pending; further ticks while pending merge (no queue).
REQ-024 spawn_ready SHALL equal (state==IDLE) && any slot inactive; accepted letter SHALL be written to lowest-index inactive slot with active=1, fields copied unmodified.
REQ-025 key_ready SHALL equal (state==IDLE) && !tick_pending && !frame_tick; accepted key_ch latched, next state SCAN with scan index 0.
REQ-026 IDLE with tick_pending or frame_tick SHALL go to MOVE (tick has priority over key); tick_pending clears on entering MOVE.
REQ-027 A spawn and a key or tick accepted in the same IDLE cycle SHALL both take effect; the new slot participates in the following MOVE/SCAN.
REQ-028 MOVE (one cycle): for every active slot, sum = x + speed in 10 bits; if sum >= X_LIMIT slot goes inactive, else x <= sum[8:0]; then IDLE.
REQ-029 MOVE SHALL add the number of slots deactivated to miss_count, saturating at 255, and pulse miss_pulse on the exit edge if that number is nonzero.
REQ-030 SCAN SHALL examine one slot per cycle, index 0..SLOTS-1; candidate if active && ch == latched key; best updated only when candidate x is strictly greater, so ties keep lowest index.
REQ-031 After index SLOTS-1, state SHALL go to RESOLVE; RESOLVE clears best slot's active, score += 1 saturating at 65535, hit_pulse; else wrong_pulse; then IDLE.
REQ-032 Key accepted on edge E0 SHALL produce hit_pulse or wrong_pulse high from edge E9 to edge E10.
REQ-033 Slots SHALL not move during SCAN/RESOLVE; spawn_ready and key_ready SHALL be low outside IDLE.
REQ-034 rd_* outputs SHALL reflect register contents with zero latency; inactive slots still report stored fields.

Reset
REQ-035 rst high SHALL immediately force state IDLE, all slots inactive with zeroed fields, tick_pending 0, score 0, miss_count 0, all pulses 0; an in-progress SCAN is abandoned with no pulse.

Verification
REQ-036 Spawn 'a' speed 3 x=0, then 4 ticks -> rd_x of slot 0 = 12, rd_active=1.
REQ-037 Slot 'b' at x=478 speed 2, tick -> slot inactive, miss_pulse one cycle, miss_count=1.
REQ-038 Slots 0,1,2 hold 'c' at x=10,50,50; key 'c' -> hit_pulse at E9, slot 1 cleared, slots 0 and 2 remain, score=1.
REQ-039 Key 'z' with no 'z' active -> wrong_pulse at E9, score unchanged, all slots unchanged.
REQ-040 Fill 8 slots -> spawn_ready=0; frame_tick during SCAN -> MOVE runs immediately after RESOLVE; key_ready low while tick pending.
REQ-041 Assert rst mid-SCAN -> all outputs reset asynchronously, no hit/wrong pulse afterward, spawn_ready=1 after release.
